rk4_multi_clock_divider: RTL and testbench
==========================================

# rk4_multi_clock_divider

Multi-channel, runtime-programmable successor to the RK4 fixed divide-by-100 clock divider. It generates NUM_CH independent 50 %-duty divided clocks from a single `clk_in`. Each channel has:
- a per-channel enable with glitch-free stop,
- a shadowed divide ratio that only takes effect at a period boundary,
- a one-cycle rising-edge tick.

It sits at the top of the RK4 datapath and feeds the stage/step clock enables and slower peripheral clocks.

## Interface
Parameters:
- NUM_CH, 4: number of output channels (1..16).
- CNT_W, 6: half-period counter width.
- DEFAULT_DIV, 49: reset value of every channel's divide value D. Half-period = D+1 `clk_in` cycles, so the default gives divide-by-100.

Ports:
- clk_in  input  1  source clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- ch_en  input  NUM_CH  per-channel run request, level-sensitive.
- wr_en  input  1  divide-value write strobe.
- wr_ch  input  $clog2(NUM_CH) (min 1)  channel index for the write.
- wr_div  input  CNT_W  new divide value D, unsigned; 0 is legal (divide-by-2).
- sync  input  1  one-cycle pulse; phase-aligns all running channels.
- clk_out  output  NUM_CH  divided clocks, registered.
- tick  output  NUM_CH  one-cycle pulse, high in the cycle clk_out[i] rises.
- pend  output  NUM_CH  high while channel i holds an unapplied divide value.

## Operation
- Per-channel state: cnt[CNT_W], clk_out, active_div, pending_div, pend, and a 2-bit FSM.
- Reset (async assert) sets every channel to: cnt=0, clk_out=0, tick=0, pend=0, active_div=DEFAULT_DIV, state IDLE.
- FSM states: IDLE, RUN, STOP.
  - IDLE: cnt=0, clk_out=0. If ch_en[i]=1, go to RUN with cnt=0.
  - RUN: if cnt >= active_div, set cnt=0 and toggle clk_out; otherwise cnt+1. If ch_en[i]=0 and clk_out=0 at a boundary, go to IDLE. If ch_en[i]=0 otherwise, go to STOP.
  - STOP: count as in RUN until the toggle that drives clk_out 1->0, then go to IDLE. If ch_en[i]=1 is seen in STOP, return to RUN with no phase disturbance.
- Period boundary: the toggle that drives clk_out 1->0, or any toggle while clk_out=0 at the moment ch_en drops.
- Divide writes:
  - wr_en with wr_ch >= NUM_CH is ignored.
  - Write to an IDLE channel: active_div=wr_div next cycle; pend stays 0.
  - Write to a RUN/STOP channel: pending_div=wr_div and pend=1. A later write before the boundary overwrites pending_div (last write wins).
  - At a period boundary with pend=1: active_div=pending_div and pend=0. Only the clk_out 1->0 boundary applies pending values, so high and low phases of one period always use the same D.
  - Write in the same cycle as a boundary: the boundary applies the previously held pending value (if any). The new value becomes pending and applies at the next boundary.
- Comparison uses >=, so a smaller D can never cause a counter overrun.
- sync=1 takes priority over counting. Every channel in RUN/STOP gets cnt=0 and clk_out=0, applies any pending value, and clears pend. A STOP channel goes to IDLE. IDLE channels are unaffected.
  - The resulting shortened high phase is intentional and documented.
  - A write in the same cycle as sync becomes pending after the sync.
- tick[i] is registered alongside clk_out[i]; it is high exactly in the cycles where clk_out[i] changes 0->1.
- Channels are fully independent apart from the shared write port and sync.

## Timing
- All outputs are registered; no combinational input-to-output path.
- IDLE channel that samples ch_en=1 at edge k: first clk_out rise at edge k+D+1, then toggles every D+1 edges. Period is 2(D+1) cycles; duty is exactly 50 %.
- With DEFAULT_DIV=49: clk_out rises at edge k+50 and period is 100 cycles, matching the legacy divider.
- Write latency to an IDLE channel is 1 cycle. For a running channel, the new D takes effect on the first half-period after the next 1->0 toggle.
- Stop latency: at most one full current period. clk_out never produces a high pulse shorter than D+1 cycles except via sync.
- reset asserted mid-operation forces all outputs to 0 immediately (async). Deassertion must be synchronised externally to clk_in.

## Test plan
1. Reset release, ch_en=all 1, defaults -> every clk_out rises at cycle 50, period 100; tick pulses at cycles 50, 150, 250.
2. Channel 1 running D=49; write wr_div=4 at cycle 70 (high phase) -> pend[1]=1 until the 1->0 toggle at cycle 100. Then high phases are 5 cycles and the period is 10; pend[1]=0.
3. Write D=0 to an IDLE channel 2, then enable -> clk_out[2] toggles every cycle (divide-by-2); tick every 2 cycles.
4. Drop ch_en[0] 10 cycles into a high phase -> the high phase completes its full 50 cycles, clk_out[0] falls, the channel idles at 0, and there are no further ticks.
5. sync pulse at cycle 120 with channels at different phases and a pending write -> all running clk_out=0 and cnt=0 next cycle, pending applied, all rise together D+1 cycles later.
6. Out-of-range wr_ch write; reset asserted mid-period -> the write has no effect; all outputs are 0 asynchronously and active_div returns to 49.

Source files
------------

// File: rtl/rk4_multi_clock_divider.sv
// rk4_multi_clock_divider
// NUM_CH independent 50 %-duty clock dividers driven from clk_in. Each channel has a
// half-period of D+1 clk_in cycles, where D is a runtime-programmable divide value.
// A new D written while a channel runs is held and only applied on the clk_out 1->0
// toggle, so the high and low phases of one period always use the same D.
//
// Ports:
//   clk_in   source clock, all state on its rising edge
//   reset    asynchronous active-low reset
//   ch_en    per-channel run request (level)
//   wr_en    divide-value write strobe; wr_ch selects channel, wr_div is the new D
//   sync     one-cycle pulse, restarts every running channel from phase 0
//   clk_out  registered divided clocks
//   tick     one-cycle pulse in the cycle clk_out[i] rises
//   pend     channel holds a divide value not yet applied
module rk4_multi_clock_divider #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned DEFAULT_DIV = 49,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] active_q, active_d;
        logic [CNT_W-1:0] pending_q, pending_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             pend_q, pend_d;
        logic             wr_hit;
        logic             at_toggle;

        // Indices >= NUM_CH match no channel, so out-of-range writes drop out here.
        assign wr_hit    = wr_en && (wr_ch == CH_W'(i));
        // >= rather than == so shrinking D mid-count can never overrun the counter.
        assign at_toggle = (cnt_q >= active_q);

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            clk_d     = clk_q;
            active_d  = active_q;
            pending_d = pending_q;
            pend_d    = pend_q;

            if (state_q == StIdle) begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (ch_en[i]) begin
                    state_d = StRun;
                end
                // Idle channels take the new value directly; nothing is pending.
                if (wr_hit) begin
                    active_d = wr_div;
                end
            end else begin
                if (sync) begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                    if (pend_q) begin
                        active_d = pending_q;
                    end
                    pend_d = 1'b0;
                    if (state_q == StStop) begin
                        state_d = StIdle;
                    end
                end else if (at_toggle) begin
                    cnt_d = '0;
                    clk_d = ~clk_q;
                    if (clk_q || !ch_en[i]) begin
                        // Period boundary: falling toggle, or a rise suppressed
                        // because the channel is stopping during its low phase.
                        clk_d = 1'b0;
                        if (pend_q) begin
                            active_d = pending_q;
                        end
                        pend_d  = 1'b0;
                        state_d = ch_en[i] ? StRun : StIdle;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ch_en[i] ? StRun : StStop;
                end

                // Evaluated after any boundary/sync so a coincident write becomes
                // the next pending value rather than being lost.
                if (wr_hit) begin
                    if (state_d == StIdle) begin
                        active_d = wr_div;
                        pend_d   = 1'b0;
                    end else begin
                        pending_d = wr_div;
                        pend_d    = 1'b1;
                    end
                end
            end

            tick_d = ~clk_q & clk_d;
        end

        always_ff @(posedge clk_in or negedge reset) begin
            if (!reset) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
                pend_q    <= 1'b0;
                active_q  <= CNT_W'(DEFAULT_DIV);
                pending_q <= CNT_W'(DEFAULT_DIV);
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                clk_q     <= clk_d;
                tick_q    <= tick_d;
                pend_q    <= pend_d;
                active_q  <= active_d;
                pending_q <= pending_d;
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pend[i]    = pend_q;
    end

endmodule

// File: tb/tb_rk4_multi_clock_divider.sv
// Directed bench for rk4_multi_clock_divider with three channels (so that wr_ch = 3 is
// an out-of-range index). Edge names below count rising edges of clk_in; outputs are
// sampled 1 time unit after the edge.
module tb_rk4_multi_clock_divider;

    localparam int unsigned NCH = 3;

    logic           clk_in = 1'b0;
    logic           reset;
    logic [NCH-1:0] ch_en;
    logic           wr_en;
    logic [1:0]     wr_ch;
    logic [5:0]     wr_div;
    logic           sync;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;

    int n_cmp = 0;
    int n_bad = 0;

    rk4_multi_clock_divider #(
        .NUM_CH      (NCH),
        .CNT_W       (6),
        .DEFAULT_DIV (49)
    ) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .ch_en   (ch_en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [NCH-1:0] e_clk,
                           input logic [NCH-1:0] e_tick, input logic [NCH-1:0] e_pend);
        chk({tag, ".clk_out"}, 32'(clk_out), 32'(e_clk));
        chk({tag, ".tick"},    32'(tick),    32'(e_tick));
        chk({tag, ".pend"},    32'(pend),    32'(e_pend));
    endtask

    initial begin
        reset  = 1'b1;
        ch_en  = '0;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_div = '0;
        sync   = 1'b0;
        #1 reset = 1'b0;
        #1 chk_all("reset", 3'b000, 3'b000, 3'b000);
        step(2);
        chk_all("reset_hold", 3'b000, 3'b000, 3'b000);

        // Defaults, all channels enabled: edge E0 starts them, rise at E0+50.
        reset = 1'b1;
        ch_en = 3'b111;
        step(1);
        chk_all("e0", 3'b000, 3'b000, 3'b000);
        step(49);
        chk_all("e49", 3'b000, 3'b000, 3'b000);
        step(1);
        chk_all("e50_rise", 3'b111, 3'b111, 3'b000);
        step(1);
        chk_all("e51", 3'b111, 3'b000, 3'b000);

        // Write D=4 to running ch1 in its high phase; applies at the E0+100 fall.
        step(18);
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 6'd4;
        step(1);
        wr_en = 1'b0;
        chk_all("e70_pend", 3'b111, 3'b000, 3'b010);
        step(29);
        chk_all("e99_pend", 3'b111, 3'b000, 3'b010);
        step(1);
        chk_all("e100_fall", 3'b000, 3'b000, 3'b000);
        step(4);
        chk_all("e104", 3'b000, 3'b000, 3'b000);
        step(1);
        chk_all("e105_ch1_rise", 3'b010, 3'b010, 3'b000);
        step(5);
        chk_all("e110_ch1_fall", 3'b000, 3'b000, 3'b000);
        step(40);
        chk_all("e150", 3'b101, 3'b101, 3'b000);

        // Drop ch_en[0] 10 cycles into its high phase: full high phase, then idle.
        step(9);
        ch_en = 3'b110;
        step(1);
        chk_all("e160_stop", 3'b101, 3'b000, 3'b000);
        step(39);
        chk_all("e199", 3'b111, 3'b000, 3'b000);
        step(1);
        chk_all("e200_fall", 3'b000, 3'b000, 3'b000);

        // Write to ch1 on the same edge as its 1->0 toggle: becomes pending.
        step(49);
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 6'd7;
        step(1);
        wr_en = 1'b0;
        chk_all("e250_no_ch0", 3'b100, 3'b100, 3'b010);

        // Asynchronous reset mid-period.
        reset = 1'b0;
        ch_en = 3'b000;
        #1 chk_all("async_reset", 3'b000, 3'b000, 3'b000);
        #1 reset = 1'b1;

        // Out-of-range write, then D=0 to idle ch2, then enable ch1 and ch2 (edge F3).
        wr_en = 1'b1; wr_ch = 2'd3; wr_div = 6'd0;
        step(1);
        wr_ch = 2'd2;
        step(1);
        wr_en = 1'b0;
        ch_en = 3'b110;
        step(1);
        chk_all("f3", 3'b000, 3'b000, 3'b000);
        step(1);
        chk_all("f4_div2_rise", 3'b100, 3'b100, 3'b000);
        step(1);
        chk_all("f5_div2_fall", 3'b000, 3'b000, 3'b000);
        step(1);
        chk_all("f6_div2_rise", 3'b100, 3'b100, 3'b000);
        step(46);
        chk_all("f52", 3'b100, 3'b100, 3'b000);
        step(1);
        chk_all("f53_ch1_default", 3'b010, 3'b010, 3'b000);

        // Sync with three channels at different phases and a pending write on ch1.
        ch_en = 3'b111;
        step(6);
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 6'd3;
        step(1);
        wr_en = 1'b0;
        chk_all("f60_pend", 3'b110, 3'b100, 3'b010);
        step(9);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk_all("f70_sync", 3'b000, 3'b000, 3'b000);
        step(1);
        chk_all("f71_ch2", 3'b100, 3'b100, 3'b000);
        step(3);
        chk_all("f74_ch1_new_div", 3'b010, 3'b010, 3'b000);
        step(4);
        chk_all("f78", 3'b000, 3'b000, 3'b000);
        step(42);
        chk_all("f120_ch0", 3'b001, 3'b001, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
